// File: rtl/debug_arbiter.sv
// Shares one console write port among N_REQ requesters.
// Each requester fills a private line buffer; whole lines drain round-robin.
module debug_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          LINE_DEPTH   = 16,
  parameter logic [23:0] CONSOLE_ADDR = 24'h000000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         wr_i,
  input  logic [8*N_REQ-1:0]       wdata_i,
  output logic [N_REQ-1:0]         ready_o,
  input  logic                     flush_i,
  output logic                     dbg_en_o,
  output logic                     dbg_we_o,
  output logic [23:0]              dbg_addr_o,
  output logic [31:0]              dbg_data_o,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(LINE_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(N_REQ);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [GW-1:0]    gnt_q;
  logic [GW-1:0]    last_q;
  logic [GW-1:0]    pick;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] one_left;
  logic [7:0]       head [N_REQ];
  logic             any_pend;
  logic             pop;
  logic             last_pop;

  assign ready_o  = ~pend;
  assign any_pend = |pend;
  assign pop      = (state_q == DRAIN);
  assign last_pop = pop && one_left[gnt_q];

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    logic [7:0]    mem [LINE_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [7:0]    wb;
    logic          acc;
    logic          popi;
    logic          term;
    logic          pend_r;

    assign wb     = wdata_i[8*i +: 8];
    assign acc    = wr_i[i] && !pend_r;
    assign popi   = pop && (gnt_q == GW'(i));
    assign term   = (wb == 8'h00) || (wb == 8'h0A);
    assign cnt_nx = cnt + CW'(acc) - CW'(popi);

    assign pend[i]     = pend_r;
    assign one_left[i] = (cnt == CW'(1));
    assign head[i]     = mem[rptr];

    // Line buffer storage; contents need no reset.
    always_ff @(posedge clk_i) begin
      if (acc) mem[wptr] <= wb;
    end

    // Pointers, fill count and line-pending flag.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wptr   <= '0;
        rptr   <= '0;
        cnt    <= '0;
        pend_r <= 1'b0;
      end else begin
        if (acc)  wptr <= wptr + AW'(1);
        if (popi) rptr <= rptr + AW'(1);
        cnt <= cnt_nx;
        if (popi && cnt == CW'(1))
          pend_r <= 1'b0;
        else if (acc && (term || cnt_nx == CW'(LINE_DEPTH)))
          pend_r <= 1'b1;
        else if (flush_i && cnt_nx != '0)
          pend_r <= 1'b1;
      end
    end
  end

  // Round-robin pick: first pending index after last_q.
  always_comb begin
    int   idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && pend[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gnt_q  <= '0;
      last_q <= GW'(N_REQ - 1);
    end else begin
      if (state_q == IDLE && any_pend) gnt_q <= pick;
      if (last_pop) last_q <= gnt_q;
    end
  end

  // Next-state logic: one idle cycle always separates lines.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_pend) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Console outputs, active only while draining.
  always_comb begin
    dbg_en_o   = 1'b0;
    dbg_data_o = '0;
    grant_o    = '0;
    if (state_q == DRAIN) begin
      dbg_en_o   = 1'b1;
      dbg_data_o = {24'h0, head[gnt_q]};
      grant_o    = gnt_q;
    end
  end

  assign dbg_we_o   = dbg_en_o;
  assign busy_o     = dbg_en_o;
  assign dbg_addr_o = CONSOLE_ADDR;

endmodule
